// File: rtl/sr_latch_driver.sv
// sr_latch_driver: debounces two bouncy buttons into clean, never-overlapping S/R pulses for an SR latch
module sr_latch_driver #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3,
   parameter int PULSE_WIDTH     = 2,
   parameter int PW_W            = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic reset_btn,
   output logic S,
   output logic R,
   output logic busy,
   output logic overrun
);
   typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
   state_t st, nxt;
   logic [1:0] sync1, sync2, db, db_q, req;
   logic [1:0][CNT_W-1:0] cnt;
   logic [PW_W-1:0] pc;
   logic pend_s, pend_r;
   assign req  = db & ~db_q;
   assign busy = (st != IDLE) | pend_s | pend_r;
   // bit 0 is the set channel, bit 1 the reset channel: synchronize, debounce, keep last debounced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_q  <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= {reset_btn, set_btn};
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) cnt[i] <= '0;
            else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
   // reset requests win over set requests; every pulse is followed by one GAP cycle and then IDLE
   always_comb begin
      nxt = st;
      case (st)
         IDLE:             nxt = (pend_r | req[1]) ? PULSE_R : (pend_s | req[0]) ? PULSE_S : IDLE;
         PULSE_S, PULSE_R: nxt = (pc == PW_W'(PULSE_WIDTH - 1)) ? GAP : st;
         GAP:              nxt = IDLE;
         default:          nxt = IDLE;
      endcase
   end
   // state, pulse width counter, registered S/R, pending flags and sticky lost-press flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         pc      <= '0;
         S       <= 1'b0;
         R       <= 1'b0;
         pend_s  <= 1'b0;
         pend_r  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         st      <= nxt;
         pc      <= (nxt == st && (st == PULSE_S || st == PULSE_R)) ? pc + 1'b1 : '0;
         S       <= nxt == PULSE_S;
         R       <= nxt == PULSE_R;
         pend_s  <= (st == IDLE && nxt == PULSE_S) ? 1'b0 : (req[0] && st != PULSE_S) ? 1'b1 : pend_s;
         pend_r  <= (st == IDLE && nxt == PULSE_R) ? 1'b0 : (req[1] && st != PULSE_R) ? 1'b1 : pend_r;
         overrun <= overrun | (req[0] & (pend_s | (st == PULSE_S))) | (req[1] & (pend_r | (st == PULSE_R)));
      end
   end
endmodule
